trap_csr_ctrl: RTL and testbench

- Machine-mode trap/CSR state block directly downstream of the commit-stage exception controller.
- Consumes its trap, mret, wfi, retired, ecp, ecause and interrupt outputs.
- Updates mstatus, mepc, mcause and minstret, and drives the pipeline redirect/flush.
- Feeds the gated sip/tip/eip pending lines back to the exception controller and implements the WFI sleep state machine.

---
 rtl/trap_csr_ctrl_pkg.sv | 44 ++++
 rtl/trap_csr_ctrl_minstret_counter.sv | 28 ++
 rtl/trap_csr_ctrl.sv | 177 +++++++++++++++++
 tb/tb_trap_csr_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_csr_ctrl_pkg.sv
// Shared constants for the machine-mode trap/CSR block: CSR addresses, bit indices, WFI states.
// Honours TRAP_VECTORED_EN (vectored mtvec mode bit writable).
package trap_csr_ctrl_pkg;

    localparam int DEF_PC_WIDTH = 32;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MSIE_BIT = 3;
    localparam int MTIE_BIT = 7;
    localparam int MEIE_BIT = 11;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFD;
`else
    localparam logic [31:0] MTVEC_WMASK = 32'hFFFF_FFFC;
`endif

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } wfi_state_e;

    function automatic logic [31:0] mip_word(input logic msip, input logic mtip, input logic meip);
        logic [31:0] w;
        w           = '0;
        w[MSIE_BIT] = msip;
        w[MTIE_BIT] = mtip;
        w[MEIE_BIT] = meip;
        return w;
    endfunction

endpackage

// File: rtl/trap_csr_ctrl_minstret_counter.sv
// 64-bit retired-instruction counter; a write to either half replaces that half and drops the increment.
module trap_csr_ctrl_minstret_counter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata,
    input  logic        i_inc,
    output logic [63:0] o_count
);

    logic [63:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_we_lo) begin
            r_count[31:0] <= i_wdata;
        end else if (i_we_hi) begin
            r_count[63:32] <= i_wdata;
        end else if (i_inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/trap_csr_ctrl.sv
// Machine-mode trap/CSR state: mstatus/mie/mtvec/mepc/mcause/minstret, redirect pulse and WFI sleep FSM.
// TRAP_VECTORED_EN enables mtvec vectored mode for interrupts.
module trap_csr_ctrl
    import trap_csr_ctrl_pkg::*;
#(
    parameter int          PC_WIDTH  = DEF_PC_WIDTH,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                trapped,
    input  logic                mret,
    input  logic                wfi,
    input  logic                retired,
    input  logic [31:0]         ecp,
    input  logic [3:0]          ecause,
    input  logic                interupt,
    input  logic                msip_in,
    input  logic                mtip_in,
    input  logic                meip_in,
    output logic                sip,
    output logic                tip,
    output logic                eip,
    input  logic                csr_we,
    input  logic [11:0]         csr_waddr,
    input  logic [31:0]         csr_wdata,
    input  logic [11:0]         csr_raddr,
    output logic [31:0]         csr_rdata,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                flush,
    output logic                sleeping
);

    logic                r_mstatus_mie;
    logic                r_mstatus_mpie;
    logic [31:0]         r_mie;
    logic [31:0]         r_mtvec;
    logic [31:0]         r_mepc;
    logic [31:0]         r_mcause;
    wfi_state_e          r_state;
    logic                r_sleeping;
    logic [31:0]         r_resume_pc;
    logic                r_redirect_valid;
    logic [PC_WIDTH-1:0] r_redirect_pc;

    logic [31:0] w_mip;
    logic        w_csr_wr;
    logic        w_wake;
    logic [31:0] w_mtvec_base;
    logic [31:0] w_trap_target;
    logic [63:0] w_minstret;

    assign w_mip        = mip_word(msip_in, mtip_in, meip_in);
    assign w_csr_wr     = csr_we && !trapped && !mret;
    assign w_wake       = (r_state == ST_SLEEP) && ((w_mip & r_mie) != '0);
    assign w_mtvec_base = {r_mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign w_trap_target = (r_mtvec[0] && interupt) ? w_mtvec_base + {26'd0, ecause, 2'b00}
                                                    : w_mtvec_base;
`else
    assign w_trap_target = w_mtvec_base;
`endif

    assign sip = msip_in & r_mie[MSIE_BIT] & r_mstatus_mie;
    assign tip = mtip_in & r_mie[MTIE_BIT] & r_mstatus_mie;
    assign eip = meip_in & r_mie[MEIE_BIT] & r_mstatus_mie;

    trap_csr_ctrl_minstret_counter u_minstret (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_we_lo (w_csr_wr && (csr_waddr == CSR_MINSTRET)),
        .i_we_hi (w_csr_wr && (csr_waddr == CSR_MINSTRETH)),
        .i_wdata (csr_wdata),
        .i_inc   (retired),
        .o_count (w_minstret)
    );

    // Trap beats mret beats CSR write; the losing write is silently dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RST & MTVEC_WMASK;
            r_mepc         <= '0;
            r_mcause       <= '0;
        end else if (trapped) begin
            r_mepc         <= {ecp[31:2], 2'b00};
            r_mcause       <= {interupt, 27'd0, ecause};
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (csr_we) begin
            case (csr_waddr)
                CSR_MSTATUS: begin
                    r_mstatus_mie  <= csr_wdata[MIE_BIT];
                    r_mstatus_mpie <= csr_wdata[MPIE_BIT];
                end
                CSR_MIE:    r_mie    <= csr_wdata & MIE_MASK;
                CSR_MTVEC:  r_mtvec  <= csr_wdata & MTVEC_WMASK;
                CSR_MEPC:   r_mepc   <= {csr_wdata[31:2], 2'b00};
                CSR_MCAUSE: r_mcause <= csr_wdata;
                default: ;
            endcase
        end
    end

    // Wake from SLEEP ignores global MIE; with MIE clear nothing traps upstream, so resume here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_RUN;
            r_sleeping       <= 1'b0;
            r_resume_pc      <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= 1'b0;
            if (trapped) begin
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= PC_WIDTH'(w_trap_target);
            end else if (mret) begin
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= PC_WIDTH'(r_mepc);
            end else if (w_wake && !r_mstatus_mie) begin
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= PC_WIDTH'(r_resume_pc);
            end
            case (r_state)
                ST_RUN: begin
                    if (wfi && !trapped) begin
                        r_state     <= ST_SLEEP;
                        r_sleeping  <= 1'b1;
                        r_resume_pc <= ecp;
                    end
                end
                ST_SLEEP: begin
                    if (trapped || w_wake) begin
                        r_state    <= ST_RUN;
                        r_sleeping <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_sleeping <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_MSTATUS: begin
                csr_rdata[MIE_BIT]  = r_mstatus_mie;
                csr_rdata[MPIE_BIT] = r_mstatus_mpie;
            end
            CSR_MIE:       csr_rdata = r_mie;
            CSR_MTVEC:     csr_rdata = r_mtvec;
            CSR_MEPC:      csr_rdata = r_mepc;
            CSR_MCAUSE:    csr_rdata = r_mcause;
            CSR_MIP:       csr_rdata = w_mip;
            CSR_MINSTRET:  csr_rdata = w_minstret[31:0];
            CSR_MINSTRETH: csr_rdata = w_minstret[63:32];
            default:       csr_rdata = '0;
        endcase
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_redirect_valid;
    assign sleeping       = r_sleeping;

endmodule

// File: tb/tb_trap_csr_ctrl.sv
// Directed and randomized checks of trap_csr_ctrl against a behavioural model of the CSR/trap rules.
module tb_trap_csr_ctrl;

    logic        clk;
    logic        reset;
    logic        trapped, mret, wfi, retired;
    logic [31:0] ecp;
    logic [3:0]  ecause;
    logic        interupt;
    logic        msip_in, mtip_in, meip_in;
    logic        sip, tip, eip;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        sleeping;

    trap_csr_ctrl #(
        .PC_WIDTH  (32),
        .MTVEC_RST (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .trapped        (trapped),
        .mret           (mret),
        .wfi            (wfi),
        .retired        (retired),
        .ecp            (ecp),
        .ecause         (ecause),
        .interupt       (interupt),
        .msip_in        (msip_in),
        .mtip_in        (mtip_in),
        .meip_in        (meip_in),
        .sip            (sip),
        .tip            (tip),
        .eip            (eip),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .csr_raddr      (csr_raddr),
        .csr_rdata      (csr_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .sleeping       (sleeping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;

    // Reference model state
    logic        m_mie_b, m_mpie;
    logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_resume, m_rpc;
    logic [63:0] m_inst;
    logic        m_sleep, m_rv;

    logic [11:0] addr_tab [0:10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mie_b = 0; m_mpie = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
        m_resume = 0; m_rpc = 0; m_inst = 0; m_sleep = 0; m_rv = 0;
    endtask

    function automatic logic [31:0] model_mip();
        return (32'(meip_in) << 11) | (32'(mtip_in) << 7) | (32'(msip_in) << 3);
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return (32'(m_mpie) << 7) | (32'(m_mie_b) << 3);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return model_mip();
            12'hB02: return m_inst[31:0];
            12'hB82: return m_inst[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_target();
        logic [31:0] base;
        base = m_mtvec & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
        if (m_mtvec[0] && interupt) return base + 32'(ecause) * 4;
`endif
        return base;
    endfunction

    task automatic clear_inputs();
        trapped = 0; mret = 0; wfi = 0; retired = 0; csr_we = 0;
        csr_waddr = 0; csr_wdata = 0; ecp = 0; ecause = 0; interupt = 0;
    endtask

    task automatic check_csr(input logic [11:0] a);
        csr_raddr = a;
        #1;
        chk($sformatf("csr_%03h", a), csr_rdata, model_read(a));
    endtask

    // One clock: predict from current model + inputs, clock, then compare outputs.
    task automatic step();
        logic        wake, wr;
        logic        n_mie_b, n_mpie, n_sleep, n_rv;
        logic [31:0] n_mie, n_mtvec, n_mepc, n_mcause, n_resume, n_rpc;
        logic [63:0] n_inst;
        wake = m_sleep && ((model_mip() & m_mie) != 0);
        wr   = csr_we && !trapped && !mret;
        n_mie_b = m_mie_b; n_mpie = m_mpie; n_mie = m_mie; n_mtvec = m_mtvec;
        n_mepc = m_mepc; n_mcause = m_mcause; n_resume = m_resume;
        n_rv = 0; n_rpc = m_rpc; n_inst = m_inst; n_sleep = m_sleep;
        if (trapped) begin
            n_mepc   = ecp & 32'hFFFF_FFFC;
            n_mcause = (32'(interupt) << 31) | 32'(ecause);
            n_mpie   = m_mie_b;
            n_mie_b  = 0;
            n_rv     = 1;
            n_rpc    = model_target();
        end else if (mret) begin
            n_mie_b = m_mpie;
            n_mpie  = 1;
            n_rv    = 1;
            n_rpc   = m_mepc;
        end else begin
            if (wr) begin
                case (csr_waddr)
                    12'h300: begin n_mie_b = csr_wdata[3]; n_mpie = csr_wdata[7]; end
                    12'h304: n_mie = csr_wdata & 32'h888;
`ifdef TRAP_VECTORED_EN
                    12'h305: n_mtvec = csr_wdata & 32'hFFFF_FFFD;
`else
                    12'h305: n_mtvec = csr_wdata & 32'hFFFF_FFFC;
`endif
                    12'h341: n_mepc = csr_wdata & 32'hFFFF_FFFC;
                    12'h342: n_mcause = csr_wdata;
                    default: ;
                endcase
            end
            if (wake && !m_mie_b) begin
                n_rv  = 1;
                n_rpc = m_resume;
            end
        end
        if (wr && csr_waddr == 12'hB02)      n_inst = {m_inst[63:32], csr_wdata};
        else if (wr && csr_waddr == 12'hB82) n_inst = {csr_wdata, m_inst[31:0]};
        else if (retired)                    n_inst = m_inst + 64'd1;
        if (trapped)                n_sleep = 0;
        else if (!m_sleep && wfi) begin n_sleep = 1; n_resume = ecp; end
        else if (wake)              n_sleep = 0;

        @(posedge clk);
        #1;
        m_mie_b = n_mie_b; m_mpie = n_mpie; m_mie = n_mie; m_mtvec = n_mtvec;
        m_mepc = n_mepc; m_mcause = n_mcause; m_resume = n_resume;
        m_rv = n_rv; m_rpc = n_rpc; m_inst = n_inst; m_sleep = n_sleep;
        clear_inputs();
        chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        chk("flush", 32'(flush), 32'(m_rv));
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
        chk("sleeping", 32'(sleeping), 32'(m_sleep));
        chk("sip", 32'(sip), 32'(msip_in & m_mie[3] & m_mie_b));
        chk("tip", 32'(tip), 32'(mtip_in & m_mie[7] & m_mie_b));
        chk("eip", 32'(eip), 32'(meip_in & m_mie[11] & m_mie_b));
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1; csr_waddr = a; csr_wdata = d;
        step();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        addr_tab[0] = 12'h300; addr_tab[1] = 12'h304; addr_tab[2] = 12'h305;
        addr_tab[3] = 12'h341; addr_tab[4] = 12'h342; addr_tab[5] = 12'h344;
        addr_tab[6] = 12'hB02; addr_tab[7] = 12'hB82; addr_tab[8] = 12'h123;
        addr_tab[9] = 12'h340; addr_tab[10] = 12'hB00;
        clear_inputs();
        msip_in = 0; mtip_in = 0; meip_in = 0; csr_raddr = 0;
        model_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
        chk("rst_sleeping", 32'(sleeping), 32'h0);
        for (int i = 0; i < 11; i++) check_csr(addr_tab[i]);
        reset = 0;

        // Timer interrupt trap
        csr_write(12'h304, 32'h80);
        csr_write(12'h300, 32'h8);
        csr_write(12'h305, 32'h2000);
        mtip_in = 1;
        #1;
        chk("tt_tip_pending", 32'(tip), 32'h1);
        trapped = 1; ecause = 4'd7; interupt = 1; ecp = 32'h100;
        step();
        chk("tt_redirect_pc", redirect_pc, 32'h2000);
        csr_raddr = 12'h342; #1; chk("tt_mcause", csr_rdata, 32'h8000_0007);
        csr_raddr = 12'h341; #1; chk("tt_mepc", csr_rdata, 32'h100);
        csr_raddr = 12'h300; #1; chk("tt_mstatus", csr_rdata, 32'h80);
        mtip_in = 0;

        // mret back to 0x100
        mret = 1;
        step();
        chk("mret_pc", redirect_pc, 32'h100);
        csr_raddr = 12'h300; #1; chk("mret_mstatus", csr_rdata, 32'h88);

        // Trap and CSR write together: the write is dropped
        trapped = 1; ecp = 32'h40; ecause = 4'd2; csr_we = 1; csr_waddr = 12'h341; csr_wdata = 32'h200;
        step();
        csr_raddr = 12'h341; #1; chk("trapwr_mepc", csr_rdata, 32'h40);

        // minstret carry and write-over-increment
        csr_write(12'hB02, 32'hFFFF_FFFF);
        retired = 1;
        step();
        csr_raddr = 12'hB02; #1; chk("carry_lo", csr_rdata, 32'h0);
        csr_raddr = 12'hB82; #1; chk("carry_hi", csr_rdata, 32'h1);
        retired = 1; csr_we = 1; csr_waddr = 12'hB02; csr_wdata = 32'h5;
        step();
        csr_raddr = 12'hB02; #1; chk("wr_beats_inc", csr_rdata, 32'h5);
        csr_write(12'h123, 32'hDEAD_BEEF);
        check_csr(12'h123);

        // WFI with MIE=0, wake via external line
        csr_write(12'h304, 32'h800);
        wfi = 1; ecp = 32'h84;
        step();
        chk("wfi_sleeping", 32'(sleeping), 32'h1);
        step();
        meip_in = 1;
        step();
        chk("wake_sleeping", 32'(sleeping), 32'h0);
        chk("wake_pc", redirect_pc, 32'h84);
        meip_in = 0;
        wfi = 1; ecp = 32'h90;
        step();
        reset = 1;
        #1;
        chk("rst_in_sleep", 32'(sleeping), 32'h0);
        chk("rst_no_pulse", 32'(redirect_valid), 32'h0);
        model_reset();
        @(posedge clk); #1;
        reset = 0;

        // Vectored vs direct dispatch
        csr_write(12'h305, 32'h1001);
        check_csr(12'h305);
        trapped = 1; interupt = 1; ecause = 4'd11; ecp = 32'h400;
        step();
`ifdef TRAP_VECTORED_EN
        chk("vec_irq_pc", redirect_pc, 32'h102C);
`else
        chk("vec_irq_pc", redirect_pc, 32'h1000);
`endif
        trapped = 1; interupt = 0; ecause = 4'd2; ecp = 32'h404;
        step();
        chk("vec_exc_pc", redirect_pc, 32'h1000);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            msip_in = ($urandom_range(0, 5) == 0);
            mtip_in = ($urandom_range(0, 5) == 0);
            meip_in = ($urandom_range(0, 5) == 0);
            ecp      = $urandom;
            ecause   = 4'($urandom);
            interupt = 1'($urandom);
            if (m_sleep) begin
                trapped = ($urandom_range(0, 7) == 0);
            end else begin
                retired = 1'($urandom);
                case ($urandom_range(0, 9))
                    0: begin
                        trapped = 1;
                        csr_we = 1'($urandom);
                        csr_waddr = addr_tab[$urandom_range(0, 10)];
                        csr_wdata = $urandom;
                    end
                    1: mret = 1;
                    2: wfi = 1;
                    3, 4, 5, 6: begin
                        csr_we = 1;
                        csr_waddr = addr_tab[$urandom_range(0, 10)];
                        csr_wdata = $urandom;
                    end
                    default: ;
                endcase
            end
            step();
            check_csr(addr_tab[$urandom_range(0, 10)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
